// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// muldiv_pkg : shared encodings for the iterative 32-bit multiply/divide unit
// Revision   : 1.0
// ============================================================================
package muldiv_pkg;

  localparam logic [1:0] OP_MULU  = 2'b00;
  localparam logic [1:0] OP_MULHU = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_REMU  = 2'b11;

  localparam int unsigned CNT_W = 5;
  localparam logic [CNT_W-1:0] CNT_LAST = 5'd31;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/muldiv32_if.sv
`default_nettype none
// ============================================================================
// muldiv32_if : start/busy/done request bus of the multiply/divide unit
// Revision    : 1.0
// ============================================================================
interface muldiv32_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (output start, op, a, b, input busy, done, result);
  modport slave  (input start, op, a, b, output busy, done, result);
endinterface
`default_nettype wire

// File: rtl/muldiv32_ctrl.sv
`default_nettype none
// ============================================================================
// muldiv32_ctrl : IDLE/RUN/DONE sequencer, iteration counter, busy/done flags
// Revision      : 1.0
// ============================================================================
module muldiv32_ctrl
  import muldiv_pkg::*;
(
  input  wire  clk,
  input  wire  arst_n,
  input  wire  start,
  output logic load,
  output logic step,
  output logic finish,
  output logic busy,
  output logic done
);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;

  // start is only honoured outside RUN, so a pulse mid-operation is dropped
  assign load   = start && (r_state == S_IDLE || r_state == S_DONE);
  assign step   = (r_state == S_RUN);
  assign finish = step && (r_cnt == CNT_LAST);
  assign busy   = r_busy;
  assign done   = r_done;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state <= S_RUN;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == CNT_LAST) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/muldiv32.sv
`default_nettype none
// ============================================================================
// muldiv32 : iterative unsigned 32-bit MULU/MULHU/DIVU/REMU, one bit per cycle
// Revision : 1.0
// ============================================================================
module muldiv32
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input wire        clk,
  input wire        arst_n,
  muldiv32_if.slave bus
);

  logic w_load;
  logic w_step;
  logic w_finish;
  logic w_busy;
  logic w_done;

  muldiv32_ctrl u_ctrl (
    .clk    (clk),
    .arst_n (arst_n),
    .start  (bus.start),
    .load   (w_load),
    .step   (w_step),
    .finish (w_finish),
    .busy   (w_busy),
    .done   (w_done)
  );

  // r_acc is the product high word or the divide remainder; r_lo is the
  // product low word or the quotient. Both ops shift through the same pair.
  logic [1:0]      r_op;
  logic [XLEN-1:0] r_b;
  logic [XLEN-1:0] r_acc;
  logic [XLEN-1:0] r_lo;
  logic [XLEN-1:0] r_result;

  logic [XLEN:0]   w_madd;
  logic [XLEN:0]   w_dsh;
  logic [XLEN:0]   w_dsub;
  logic [XLEN-1:0] w_acc_nxt;
  logic [XLEN-1:0] w_lo_nxt;
  logic [XLEN-1:0] w_res;

  assign w_madd = {1'b0, r_acc} + {1'b0, (r_lo[0] ? r_b : {XLEN{1'b0}})};
  assign w_dsh  = {r_acc, r_lo[XLEN-1]};
  assign w_dsub = w_dsh - {1'b0, r_b};

  always_comb begin
    w_acc_nxt = r_acc;
    w_lo_nxt  = r_lo;
    if (!r_op[1]) begin
      w_acc_nxt = w_madd[XLEN:1];
      w_lo_nxt  = {w_madd[0], r_lo[XLEN-1:1]};
    end else if (!w_dsub[XLEN]) begin
      // a non-negative difference always fits XLEN bits since r < b
      w_acc_nxt = w_dsub[XLEN-1:0];
      w_lo_nxt  = {r_lo[XLEN-2:0], 1'b1};
    end else begin
      w_acc_nxt = w_dsh[XLEN-1:0];
      w_lo_nxt  = {r_lo[XLEN-2:0], 1'b0};
    end
  end

  always_comb begin
    w_res = w_lo_nxt;
    case (r_op)
      OP_MULU:  w_res = w_lo_nxt;
      OP_MULHU: w_res = w_acc_nxt;
      OP_DIVU:  w_res = w_lo_nxt;
      OP_REMU:  w_res = w_acc_nxt;
      default:  w_res = w_lo_nxt;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_op     <= OP_MULU;
      r_b      <= '0;
      r_acc    <= '0;
      r_lo     <= '0;
      r_result <= '0;
    end else begin
      if (w_load) begin
        r_op  <= bus.op;
        r_b   <= bus.b;
        r_acc <= '0;
        r_lo  <= bus.a;
      end else if (w_step) begin
        r_acc <= w_acc_nxt;
        r_lo  <= w_lo_nxt;
      end
      // the last iteration's value goes straight into the result register
      if (w_finish) begin
        r_result <= w_res;
      end
    end
  end

  assign bus.busy   = w_busy;
  assign bus.done   = w_done;
  assign bus.result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_muldiv32.sv
`default_nettype none
// ============================================================================
// tb_muldiv32 : directed and random checks of muldiv32 against an arithmetic model
// Revision    : 1.0
// ============================================================================
module tb_muldiv32;

  logic clk    = 1'b0;
  logic arst_n = 1'b1;
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  muldiv32_if #(.XLEN(32)) bus ();
  muldiv32 #(.XLEN(32)) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus)
  );

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] p;
    p = {32'b0, a} * {32'b0, b};
    case (op)
      2'd0:    return p[31:0];
      2'd1:    return p[63:32];
      2'd2:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Launches one operation from the posedge+1 phase and returns with done high.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b);
    int n;
    int nbusy;
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
    n     = 0;
    nbusy = int'(bus.busy);
    while (!bus.done && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (!bus.done) nbusy += int'(bus.busy);
    end
    chk({tag, ".latency"}, 32'(n), 32'd32);
    chk({tag, ".busy_cycles"}, 32'(nbusy), 32'd32);
    chk({tag, ".busy_at_done"}, 32'(bus.busy), 32'd0);
    chk({tag, ".result"}, bus.result, model(op, a, b));
  endtask

  task automatic idle_after(input string tag, input logic [31:0] exp);
    @(posedge clk);
    #1;
    chk({tag, ".done_pulse_width"}, 32'(bus.done), 32'd0);
    chk({tag, ".result_held"}, bus.result, exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          n;
    int          dones;
    logic [31:0] first_res;
    int          first_n;
    logic [1:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;

    bus.start = 1'b0;
    bus.op    = 2'd0;
    bus.a     = '0;
    bus.b     = '0;

    #1 arst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.busy", 32'(bus.busy), 32'd0);
    chk("reset.done", 32'(bus.done), 32'd0);
    chk("reset.result", bus.result, 32'd0);
    @(negedge clk) arst_n = 1'b1;
    @(posedge clk);
    #1;

    run_op("mulu_7x6", 2'd0, 32'd7, 32'd6);
    chk("mulu_7x6.value", bus.result, 32'h0000_002A);
    idle_after("mulu_7x6", 32'h0000_002A);

    run_op("mulu_2p16", 2'd0, 32'h0001_0000, 32'h0001_0000);
    run_op("mulhu_2p16_b2b", 2'd1, 32'h0001_0000, 32'h0001_0000);
    chk("mulhu_2p16.value", bus.result, 32'h0000_0001);
    idle_after("mulhu_2p16", 32'h0000_0001);

    run_op("mulhu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("mulhu_max.value", bus.result, 32'hFFFF_FFFE);
    run_op("mulu_max", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("mulu_max.value", bus.result, 32'h0000_0001);
    idle_after("mulu_max", 32'h0000_0001);

    run_op("divu_100_7", 2'd2, 32'd100, 32'd7);
    chk("divu_100_7.value", bus.result, 32'd14);
    run_op("remu_100_7", 2'd3, 32'd100, 32'd7);
    chk("remu_100_7.value", bus.result, 32'd2);
    idle_after("remu_100_7", 32'd2);

    run_op("divu_by0", 2'd2, 32'h1234_5678, 32'd0);
    chk("divu_by0.value", bus.result, 32'hFFFF_FFFF);
    run_op("remu_by0", 2'd3, 32'h1234_5678, 32'd0);
    chk("remu_by0.value", bus.result, 32'h1234_5678);
    idle_after("remu_by0", 32'h1234_5678);

    // start pulsed with other operands in RUN cycle 10 must be ignored
    bus.start = 1'b1; bus.op = 2'd2; bus.a = 32'd1000; bus.b = 32'd3;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    bus.start = 1'b1; bus.op = 2'd0; bus.a = 32'd5; bus.b = 32'd5;
    @(posedge clk);
    #1 bus.start = 1'b0;
    n = 10; dones = 0; first_res = '0; first_n = 0;
    while (n < 45) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.done) begin
        if (dones == 0) begin
          first_res = bus.result;
          first_n   = n;
        end
        dones++;
      end
    end
    chk("ignore_start.done_count", 32'(dones), 32'd1);
    chk("ignore_start.latency", 32'(first_n), 32'd32);
    chk("ignore_start.result", first_res, 32'd333);

    // asynchronous reset in RUN cycle 15
    bus.start = 1'b1; bus.op = 2'd0; bus.a = 32'hDEAD_BEEF; bus.b = 32'd3;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    chk("abort.busy_before", 32'(bus.busy), 32'd1);
    arst_n = 1'b0;
    #1;
    chk("abort.busy", 32'(bus.busy), 32'd0);
    chk("abort.done", 32'(bus.done), 32'd0);
    chk("abort.result", bus.result, 32'd0);
    @(negedge clk) arst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) dones++;
    end
    chk("abort.no_done", 32'(dones), 32'd0);
    run_op("mulu_3x5", 2'd0, 32'd3, 32'd5);
    chk("mulu_3x5.value", bus.result, 32'd15);
    idle_after("mulu_3x5", 32'd15);

    for (int k = 0; k < 40; k++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = ra;
        default: rb = $urandom;
      endcase
      run_op($sformatf("rand%0d", k), rop, ra, rb);
      if ($urandom_range(0, 1) == 0) idle_after($sformatf("rand%0d", k), model(rop, ra, rb));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
